// File: rtl/ble_scan_controller.sv
// BLE advertising-channel scan sequencer with packet-record FIFO.
// Optional per-record symbol timestamps: define SCAN_TIMESTAMP_EN.
module ble_scan_controller #(
    parameter int GUARD_SYMBOLS = 4,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic        symbol_clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [2:0]  chan_mask,
    input  logic [15:0] dwell_len,
    input  logic        packet_detected,
    input  logic [8:0]  packet_len,
    output logic        sniffer_en,
    output logic [5:0]  sniffer_channel,
    output logic        busy,
    output logic        overflow,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [5:0]  rd_channel,
    output logic [8:0]  rd_len,
    output logic [15:0] rd_timestamp
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [15:0] GUARD_LOAD = 16'(GUARD_SYMBOLS - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, LISTEN} state_t;

    state_t      state, state_n;
    logic [15:0] cnt, cnt_n;
    logic [15:0] dwell_q, dwell_n, dwell_load;
    logic [2:0]  mask_q, mask_n;
    logic [5:0]  chan_n;
    logic        en_n, ovf_n, pd_q;

    logic [AW:0] wptr, rptr;
    logic        full, empty, pop, push_req, push_ok;
    logic [5:0]  mem_ch  [FIFO_DEPTH];
    logic [8:0]  mem_len [FIFO_DEPTH];

    // Next enabled channel after cur, in cyclic order 37->38->39->37
    function automatic logic [5:0] next_chan(input logic [2:0] m, input logic [5:0] cur);
        logic [5:0] r;
        case (cur)
            6'd37:   r = m[1] ? 6'd38 : m[2] ? 6'd39 : m[0] ? 6'd37 : cur;
            6'd38:   r = m[2] ? 6'd39 : m[0] ? 6'd37 : m[1] ? 6'd38 : cur;
            default: r = m[0] ? 6'd37 : m[1] ? 6'd38 : m[2] ? 6'd39 : cur;
        endcase
        return r;
    endfunction

    assign dwell_load = (dwell_q == '0) ? '0 : dwell_q - 16'd1;
    assign empty      = (wptr == rptr);
    assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop        = !empty && rd_ready;
    assign push_req   = (state == LISTEN) && packet_detected && !pd_q;
    assign push_ok    = push_req && (!full || pop);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        mask_n  = mask_q;
        dwell_n = dwell_q;
        chan_n  = sniffer_channel;
        ovf_n   = overflow;
        if (stop) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && chan_mask != 3'b000) begin
                        state_n = SETTLE;
                        cnt_n   = GUARD_LOAD;
                        mask_n  = chan_mask;
                        dwell_n = dwell_len;
                        chan_n  = next_chan(chan_mask, 6'd39);
                        ovf_n   = 1'b0;
                    end
                end
                SETTLE: begin
                    if (cnt == '0) begin
                        state_n = LISTEN;
                        cnt_n   = dwell_load;
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                LISTEN: begin
                    if (cnt == '0) begin
                        state_n = SETTLE;
                        cnt_n   = GUARD_LOAD;
                        chan_n  = next_chan(mask_q, sniffer_channel);
                    end else begin
                        cnt_n = cnt - 16'd1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
        if (push_req && !push_ok)
            ovf_n = 1'b1;
        en_n = (state_n == LISTEN);
    end

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            cnt             <= '0;
            mask_q          <= '0;
            dwell_q         <= '0;
            sniffer_en      <= 1'b0;
            sniffer_channel <= 6'd37;
            overflow        <= 1'b0;
            pd_q            <= 1'b0;
        end else begin
            state           <= state_n;
            cnt             <= cnt_n;
            mask_q          <= mask_n;
            dwell_q         <= dwell_n;
            sniffer_en      <= en_n;
            sniffer_channel <= chan_n;
            overflow        <= ovf_n;
            pd_q            <= packet_detected;
        end
    end

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ch[i]  <= '0;
                mem_len[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_ch[wptr[AW-1:0]]  <= sniffer_channel;
                mem_len[wptr[AW-1:0]] <= packet_len;
                wptr                  <= wptr + 1'b1;
            end
            if (pop)
                rptr <= rptr + 1'b1;
        end
    end

    assign busy       = (state != IDLE);
    assign rd_valid   = !empty;
    assign rd_channel = mem_ch[rptr[AW-1:0]];
    assign rd_len     = mem_len[rptr[AW-1:0]];

`ifdef SCAN_TIMESTAMP_EN
    logic [15:0] ts;
    logic [15:0] mem_ts [FIFO_DEPTH];

    always_ff @(posedge symbol_clk or negedge rst) begin
        if (!rst) begin
            ts <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_ts[i] <= '0;
        end else begin
            ts <= ts + 16'd1;
            if (push_ok)
                mem_ts[wptr[AW-1:0]] <= ts;
        end
    end

    assign rd_timestamp = mem_ts[rptr[AW-1:0]];
`else
    assign rd_timestamp = '0;
`endif

endmodule

// File: tb/tb_ble_scan_controller.sv
// Self-checking bench for ble_scan_controller against a hop-schedule
// and record-queue reference model.
module tb_ble_scan_controller;
  localparam int G     = 4;
  localparam int DEPTH = 4;

  logic        symbol_clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [2:0]  chan_mask = '0;
  logic [15:0] dwell_len = '0;
  logic        packet_detected = 1'b0;
  logic [8:0]  packet_len = '0;
  logic        rd_ready = 1'b0;
  logic        sniffer_en;
  logic [5:0]  sniffer_channel;
  logic        busy;
  logic        overflow;
  logic        rd_valid;
  logic [5:0]  rd_channel;
  logic [8:0]  rd_len;
  logic [15:0] rd_timestamp;

  ble_scan_controller #(
    .GUARD_SYMBOLS(G),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .symbol_clk(symbol_clk),
    .rst(rst),
    .start(start),
    .stop(stop),
    .chan_mask(chan_mask),
    .dwell_len(dwell_len),
    .packet_detected(packet_detected),
    .packet_len(packet_len),
    .sniffer_en(sniffer_en),
    .sniffer_channel(sniffer_channel),
    .busy(busy),
    .overflow(overflow),
    .rd_valid(rd_valid),
    .rd_ready(rd_ready),
    .rd_channel(rd_channel),
    .rd_len(rd_len),
    .rd_timestamp(rd_timestamp)
  );

  always #5 symbol_clk = ~symbol_clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [5:0]  ch;
    logic [8:0]  len;
    logic [15:0] ts;
  } rec_t;

  rec_t q[$];
  bit   m_busy, m_en, m_ovf, m_pdq;
  int   m_t, m_d, m_n, m_ch, m_ts;
  int   m_chans[3];

  function automatic void m_reset();
    q.delete();
    m_busy = 0; m_en = 0; m_ovf = 0; m_pdq = 0;
    m_t = 0; m_d = 1; m_n = 1; m_ch = 37; m_ts = 0;
  endfunction

  // Position within the hop schedule: period G+dwell, listen after G guard cycles
  function automatic void m_sched();
    int p;
    p = m_t % (G + m_d);
    m_en = (p >= G);
    m_ch = m_chans[(m_t / (G + m_d)) % m_n];
  endfunction

  function automatic logic [40:0] exp_vec();
    rec_t h;
    h = '0;
    if (q.size() > 0) begin
      h = q[0];
`ifndef SCAN_TIMESTAMP_EN
      h.ts = '0;
`endif
    end
    return {m_en, 6'(m_ch), m_busy, m_ovf, q.size() > 0, h};
  endfunction

  function automatic logic [40:0] obs_vec();
    logic [15:0] t;
`ifdef SCAN_TIMESTAMP_EN
    t = rd_valid ? rd_timestamp : 16'd0;
`else
    t = rd_timestamp;
`endif
    return {sniffer_en, sniffer_channel, busy, overflow, rd_valid,
            rd_valid ? rd_channel : 6'd0, rd_valid ? rd_len : 9'd0, t};
  endfunction

  task automatic step();
    bit   do_pop, do_push;
    rec_t r;
    do_pop  = (q.size() > 0) && rd_ready;
    do_push = m_en && packet_detected && !m_pdq;
    r.ch  = 6'(m_ch);
    r.len = packet_len;
    r.ts  = 16'(m_ts);
    if (m_busy) begin
      if (stop) begin
        m_busy = 0;
        m_en   = 0;
      end else begin
        m_t++;
        m_sched();
      end
    end else if (start && !stop && chan_mask != 3'b000) begin
      m_busy = 1;
      m_t    = 0;
      m_ovf  = 0;
      m_d    = (dwell_len == 0) ? 1 : int'(dwell_len);
      m_n    = 0;
      for (int c = 0; c < 3; c++)
        if (chan_mask[c]) begin
          m_chans[m_n] = 37 + c;
          m_n++;
        end
      m_sched();
    end
    m_pdq = packet_detected;
    if (do_pop) void'(q.pop_front());
    if (do_push) begin
      if (q.size() < DEPTH) q.push_back(r);
      else m_ovf = 1;
    end
    m_ts = (m_ts + 1) % 65536;
    @(posedge symbol_clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 0; stop = 0; packet_detected = 0; rd_ready = 0;
    repeat (2) @(posedge symbol_clk);
    #1;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge symbol_clk);
    #1;
    if ({sniffer_en, sniffer_channel, busy, overflow, rd_valid, rd_channel, rd_len, rd_timestamp}
        !== {1'b0, 6'd37, 1'b0, 1'b0, 1'b0, 6'd0, 9'd0, 16'd0}) begin
      errors++;
      $display("FAIL reset got en=%b ch=%0d busy=%b ovf=%b v=%b rc=%0d rl=%0d ts=%0d want 0/37/0...",
               sniffer_en, sniffer_channel, busy, overflow, rd_valid, rd_channel, rd_len, rd_timestamp);
    end
    checks++;
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_single_hop();
    chan_mask = 3'b111; dwell_len = 16'd10; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 3 * 14 + 6; i++) begin
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_hop cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      step();
    end
    stop = 1;
    step();
    stop = 0;
    if (obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL single_hop_stop got=%h want=%h", obs_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_mask_skip();
    chan_mask = 3'b101;
    dwell_len = 16'($urandom_range(1, 6));
    start = 1;
    step();
    start = 0;
    for (int i = 0; i < 4 * (G + int'(dwell_len)); i++) begin
      if (obs_vec() !== exp_vec() || sniffer_channel === 6'd38) begin
        errors++;
        $display("FAIL mask_skip cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      step();
    end
    stop = 1;
    step();
    stop = 0;
  endtask

  task automatic test_capture();
    rd_ready = 1;
    repeat (6) step();
    rd_ready = 0;
    chan_mask = 3'b111; dwell_len = 16'd10; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 60 && !(m_ch == 38 && m_en); i++) step();
    if (sniffer_channel !== 6'd38 || sniffer_en !== 1'b1) begin
      errors++;
      $display("FAIL capture_wait got ch=%0d en=%b want 38/1", sniffer_channel, sniffer_en);
    end
    checks++;
    step();
    packet_detected = 1; packet_len = 9'd120;
    step();
    packet_detected = 0;
    step();
    if (rd_valid !== 1'b1 || rd_channel !== 6'd38 || rd_len !== 9'd120) begin
      errors++;
      $display("FAIL capture_entry got v=%b ch=%0d len=%0d want 1/38/120", rd_valid, rd_channel, rd_len);
    end
    checks++;
    packet_detected = 1; packet_len = 9'($urandom);
    repeat (3) step();
    packet_detected = 0;
    for (int i = 0; i < 8; i++) begin
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL capture_wide cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      rd_ready = (i >= 3);
      step();
    end
    rd_ready = 0;
    stop = 1;
    step();
    stop = 0;
  endtask

  task automatic test_overflow();
    logic [8:0] lens[6];
    rd_ready = 1;
    repeat (6) step();
    rd_ready = 0;
    chan_mask = 3'b001; dwell_len = 16'd300; start = 1;
    step();
    start = 0;
    repeat (G + 1) step();
    for (int k = 0; k < 6; k++) begin
      lens[k] = 9'($urandom);
      packet_detected = 1; packet_len = lens[k];
      rd_ready = (k == 5);
      step();
      packet_detected = 0; rd_ready = 0;
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL overflow_push%0d got=%h want=%h", k, obs_vec(), exp_vec());
      end
      checks++;
    end
    if (overflow !== 1'b1 || rd_len !== lens[1]) begin
      errors++;
      $display("FAIL overflow_flag got ovf=%b len=%0d want 1/%0d", overflow, rd_len, lens[1]);
    end
    checks++;
  endtask

  task automatic test_stop_restart();
    stop = 1;
    step();
    stop = 0;
    if (sniffer_en !== 1'b0 || busy !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL stop got en=%b busy=%b vec=%h want 0/0 vec=%h",
               sniffer_en, busy, obs_vec(), exp_vec());
    end
    checks++;
    chan_mask = 3'($urandom_range(1, 7));
    dwell_len = 16'($urandom_range(0, 8));
    start = 1;
    step();
    start = 0;
    if (overflow !== 1'b0 || rd_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart got ovf=%b v=%b busy=%b want 0/1/1", overflow, rd_valid, busy);
    end
    checks++;
    for (int i = 0; i < 30; i++) begin
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL restart_run cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
      step();
    end
    stop = 1;
    step();
    stop = 0;
    chan_mask = 3'b000; start = 1;
    step();
    start = 0;
    if (busy !== 1'b0 || obs_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL zero_mask got busy=%b vec=%h want 0 vec=%h", busy, obs_vec(), exp_vec());
    end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 15) == 0);
      stop  = ($urandom_range(0, 60) == 0);
      chan_mask = 3'($urandom);
      dwell_len = 16'($urandom_range(0, 12));
      packet_detected = ($urandom_range(0, 3) == 0);
      packet_len = 9'($urandom);
      rd_ready = ($urandom_range(0, 2) == 0);
      step();
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
      checks++;
    end
    start = 0; stop = 0; packet_detected = 0; rd_ready = 0;
  endtask

`ifdef SCAN_TIMESTAMP_EN
  task automatic test_timestamp();
    int cyc;
    do_reset();
    cyc = 0;
    chan_mask = 3'b001; dwell_len = 16'd65535; start = 1;
    step();
    cyc++;
    start = 0;
    while (cyc < 65601) begin
      packet_detected = (cyc == 100 || cyc == 65600);
      packet_len = 9'(cyc);
      step();
      cyc++;
      if (obs_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL ts_run cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      checks++;
    end
    packet_detected = 0;
    if (rd_timestamp !== 16'd100) begin
      errors++;
      $display("FAIL ts_first got=%0d want=100", rd_timestamp);
    end
    checks++;
    rd_ready = 1;
    step();
    rd_ready = 0;
    if (rd_timestamp !== 16'd64 || rd_valid !== 1'b1) begin
      errors++;
      $display("FAIL ts_wrap got=%0d v=%b want=64/1", rd_timestamp, rd_valid);
    end
    checks++;
  endtask
`endif

  initial begin
    m_reset();
    test_reset();
    test_single_hop();
    test_mask_skip();
    test_capture();
    test_overflow();
    test_stop_restart();
    test_random();
`ifdef SCAN_TIMESTAMP_EN
    test_timestamp();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
